sram_rport_arbiter: RTL
=======================

// Module: sram_rport_arbiter
// PURPOSE
// - Shares read-only port 1 (csb1/addr1) of the banked cache SRAM macros between two requesters: Wishbone debug and LA probe.
// - Round-robin arbitration; sequences one read at a time: bank decode, csb1 strobe, latency wait, rdata capture, ack.
// - Sits in Marmot beside the *_ext RAM wrappers; drives the *_ext_ram_csb1/*_ext_ram_addr1 pins.
// PARAMETERS
// - ADDR_W    9   word address width per macro (ram_addr1 width)
// - BANK_W    3   bank-select width; request address = {bank, word}
// - NBANKS    8   banks implemented, NBANKS <= 2**BANK_W
// - DATA_W    32  read data width per bank
// - READ_LAT  1   cycles from csb1-low cycle to valid ram_rdata, >= 1
// PORTS
// - clk        in   1                  system clock
// - rst_n      in   1                  async active-low reset
// - wb_req     in   1                  WB read request; level, held until wb_ack
// - wb_addr    in   BANK_W+ADDR_W      WB {bank, word}; stable while wb_req
// - wb_ack     out  1                  1-cycle pulse; wb_rdata valid that cycle
// - wb_rdata   out  DATA_W             WB read data (registered)
// - la_req     in   1                  LA read request; same rules as wb_req
// - la_addr    in   BANK_W+ADDR_W      LA {bank, word}
// - la_ack     out  1                  1-cycle pulse
// - la_rdata   out  DATA_W             LA read data (registered)
// - ram_csb1   out  NBANKS             per-bank port-1 chip select, active low
// - ram_addr1  out  ADDR_W             port-1 word address
// - ram_rdata  in   NBANKS*DATA_W      bank b data at [b*DATA_W +: DATA_W]
// BEHAVIOUR
// - Reset (async, rst_n low): state IDLE, ram_csb1 all 1, ram_addr1 0, acks 0, rdata 0, last_grant=LA.
// - Outputs are registered; no combinational path from req to csb1 or ack.
// - FSM IDLE -> ISSUE -> WAIT (READ_LAT-1 cycles, skipped if READ_LAT=1) -> CAPT -> RESP -> IDLE.
// - IDLE: a req seen at edge latches the granted requester and address; both high -> grant the one != last_grant.
// - ISSUE (1 cycle): ram_csb1[bank]=0, others 1; ram_addr1=word. last_grant updated here.
// - CAPT: ram_csb1 all 1; ram_rdata slice of latched bank sampled at end of cycle.
// - RESP (1 cycle): granted ack=1, its rdata updated; other requester's ack/rdata unchanged.
// - Latency: req high in IDLE cycle N -> csb1 low in N+1 -> ack in N+READ_LAT+2 (N+3 at default).
// - Requester drops req the cycle after ack; req high again in IDLE = new read.
// - ram_addr1 holds last value outside ISSUE (no toggle when idle).
// - Bank >= NBANKS: no csb1 strobe in ISSUE; full sequence runs; ack with rdata = 0.
// - Req deasserted before ack: protocol violation; the latched read still completes and acks.
// - Reset mid-operation: immediate abort to reset values; no ack issued after release.
// - Throughput: one read per READ_LAT+3 cycles; alternating service under continuous dual requests.
// CONFIGURATION
// - SRAM_RPORT_COLLISION_EN defined: adds ports ram_csb0 (in, NBANKS, active low), ram_web0 (in, 1,
//   active low), ram_addr0 (in, ADDR_W) = port-0 controls from the *_ext wrapper.
//   ISSUE stalls (csb1 held all 1, state held) while port 0 writes same bank and same word that cycle;
//   each stall cycle adds 1 to ack latency. Reads and non-matching writes never stall.
// - Undefined: ports absent, ISSUE never stalls; latency fixed at READ_LAT+2.
// TESTING
// - Reset: rst_n=0 -> ram_csb1=8'hFF, wb_ack=la_ack=0, wb_rdata=la_rdata=0, ram_addr1=0.
// - WB read: wb_addr={3'd2,9'h055}, bank2 rdata=32'hCAFE0002 -> csb1=8'hFB one cycle with addr1=9'h055;
//   wb_ack at N+3, wb_rdata=32'hCAFE0002; la_ack stays 0.
// - Contention: wb_req,la_req high same cycle after reset -> WB acked N+3, LA acked N+7;
//   repeat immediately -> WB again first (last_grant=LA), LA next.
// - Out-of-range: NBANKS=6, la_addr={3'd7,9'h010} -> ram_csb1 stays 6'h3F; la_ack N+3, la_rdata=0.
// - Abort: READ_LAT=2, rst_n low during WAIT -> csb1 all 1 at once; after release no ack, next read normal.
// - SRAM_RPORT_COLLISION_EN: port-0 write bank2 word 9'h055 in ISSUE cycle -> csb1 strobe delayed 1 cycle,
//   wb_ack at N+4; same with port-0 read (web0=1) -> no delay.

Source files
------------

// File: rtl/sram_rport_arbiter_if.sv
// Bus bundle between the port-1 read arbiter, its two requesters (WB debug, LA probe)
// and the banked SRAM port-1 pins.
interface sram_rport_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int BANK_W = 3,
   parameter int NBANKS = 8,
   parameter int DATA_W = 32
);
   // req is a level held until the matching 1-cycle ack; addr must stay stable meanwhile.
   logic                     wb_req;
   logic [BANK_W+ADDR_W-1:0] wb_addr;
   logic                     wb_ack;
   logic [DATA_W-1:0]        wb_rdata;
   logic                     la_req;
   logic [BANK_W+ADDR_W-1:0] la_addr;
   logic                     la_ack;
   logic [DATA_W-1:0]        la_rdata;
   logic [NBANKS-1:0]        ram_csb1;
   logic [ADDR_W-1:0]        ram_addr1;
   logic [NBANKS*DATA_W-1:0] ram_rdata;

   modport slave (
      input  wb_req, wb_addr, la_req, la_addr, ram_rdata,
      output wb_ack, wb_rdata, la_ack, la_rdata, ram_csb1, ram_addr1
   );

   modport master (
      output wb_req, wb_addr, la_req, la_addr, ram_rdata,
      input  wb_ack, wb_rdata, la_ack, la_rdata, ram_csb1, ram_addr1
   );
endinterface

// File: rtl/sram_rport_arbiter.sv
// Round-robin arbiter sharing SRAM read port 1 between WB debug and LA probe, one read at a time.
// Optional macro SRAM_RPORT_COLLISION_EN adds port-0 inputs and stalls ISSUE on a same-word write.
module sram_rport_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int BANK_W   = 3,
   parameter int NBANKS   = 8,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_rport_arbiter_if.slave bus,
`ifdef SRAM_RPORT_COLLISION_EN
   input  logic [NBANKS-1:0] ram_csb0,
   input  logic              ram_web0,
   input  logic [ADDR_W-1:0] ram_addr0,
`endif
   output logic [2:0]        dbg_state
);
   localparam int   AW    = BANK_W + ADDR_W;
   localparam int   CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
   localparam logic GNT_WB = 1'b0;
   localparam logic GNT_LA = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CAPT  = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic [ADDR_W-1:0]   word_q, word_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NBANKS-1:0]   csb1_q, csb1_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d;
   logic                wb_ack_q, wb_ack_d;
   logic                la_ack_q, la_ack_d;
   logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
   logic [DATA_W-1:0]   la_rdata_q, la_rdata_d;

   logic                pick_la;
   logic [AW-1:0]       pick_addr;
   logic [NBANKS-1:0]   csb_pick;
   logic [DATA_W-1:0]   rdata_sel;
   logic                stall;

   // Bank decode: a bank >= NBANKS matches no slot, so it strobes nothing and reads back 0.
   always_comb begin
      pick_la   = bus.la_req && (!bus.wb_req || (last_grant_q == GNT_WB));
      pick_addr = pick_la ? bus.la_addr : bus.wb_addr;
      csb_pick  = '1;
      rdata_sel = '0;
      for (int b = 0; b < NBANKS; b++) begin
         if (pick_addr[AW-1 -: BANK_W] == BANK_W'(b)) csb_pick[b] = 1'b0;
         if (bank_q == BANK_W'(b)) rdata_sel = bus.ram_rdata[b*DATA_W +: DATA_W];
      end
   end

`ifdef SRAM_RPORT_COLLISION_EN
   always_comb begin
      stall = 1'b0;
      if ((state_q == S_ISSUE) && !ram_web0 && (ram_addr0 == word_q)) begin
         for (int b = 0; b < NBANKS; b++) begin
            if ((bank_q == BANK_W'(b)) && !ram_csb0[b]) stall = 1'b1;
         end
      end
   end
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      bank_d       = bank_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      csb1_d       = csb1_q;
      addr1_d      = addr1_q;
      wb_ack_d     = 1'b0;
      la_ack_d     = 1'b0;
      wb_rdata_d   = wb_rdata_q;
      la_rdata_d   = la_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.wb_req || bus.la_req) begin
               grant_d = pick_la;
               bank_d  = pick_addr[AW-1 -: BANK_W];
               word_d  = pick_addr[ADDR_W-1:0];
               csb1_d  = csb_pick;
               addr1_d = pick_addr[ADDR_W-1:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               last_grant_d = grant_q;
               csb1_d       = '1;
               if (READ_LAT == 1) begin
                  state_d = S_CAPT;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(READ_LAT - 2);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_CAPT;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_CAPT: begin
            state_d = S_RESP;
            if (grant_q == GNT_LA) begin
               la_ack_d   = 1'b1;
               la_rdata_d = rdata_sel;
            end else begin
               wb_ack_d   = 1'b1;
               wb_rdata_d = rdata_sel;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= GNT_WB;
         last_grant_q <= GNT_LA;
         bank_q       <= '0;
         word_q       <= '0;
         cnt_q        <= '0;
         csb1_q       <= '1;
         addr1_q      <= '0;
         wb_ack_q     <= 1'b0;
         la_ack_q     <= 1'b0;
         wb_rdata_q   <= '0;
         la_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         bank_q       <= bank_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         csb1_q       <= csb1_d;
         addr1_q      <= addr1_d;
         wb_ack_q     <= wb_ack_d;
         la_ack_q     <= la_ack_d;
         wb_rdata_q   <= wb_rdata_d;
         la_rdata_q   <= la_rdata_d;
      end
   end

   // A colliding port-0 write masks the already-registered strobe for that ISSUE cycle.
   assign bus.ram_csb1  = csb1_q | {NBANKS{stall}};
   assign bus.ram_addr1 = addr1_q;
   assign bus.wb_ack    = wb_ack_q;
   assign bus.la_ack    = la_ack_q;
   assign bus.wb_rdata  = wb_rdata_q;
   assign bus.la_rdata  = la_rdata_q;
   assign dbg_state     = state_q;
endmodule
